// File: rtl/tetris_input_ctrl_if.sv
// Signal bundle between the joystick/button front-end and its driver/consumer.
// adc_valid is a one-way strobe: adc_value is taken on every clk edge where adc_valid=1, there is no ready/backpressure.
interface tetris_input_ctrl_if #(
  parameter int ADC_W = 12
);
  logic [ADC_W-1:0] adc_value;
  logic             adc_valid;
  logic             btn_rotate_n;
  logic             btn_drop_n;
  logic             move_left;
  logic             move_right;
  logic             move_down;
  logic             rotate;
  logic             adc_stale;

  modport master (
    output adc_value, adc_valid, btn_rotate_n, btn_drop_n,
    input  move_left, move_right, move_down, rotate, adc_stale
  );

  modport slave (
    input  adc_value, adc_valid, btn_rotate_n, btn_drop_n,
    output move_left, move_right, move_down, rotate, adc_stale
  );
endinterface

// File: rtl/tetris_input_ctrl.sv
// Joystick hysteresis zone FSM with staleness timeout, plus synchronized and
// debounced rotate / fast-drop buttons; every output is a registered level.
module tetris_input_ctrl #(
  parameter int ADC_W           = 12,
  parameter int LEFT_ON         = 1024,
  parameter int LEFT_OFF        = 1536,
  parameter int RIGHT_OFF       = 2560,
  parameter int RIGHT_ON        = 3072,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ADC_TIMEOUT     = 5_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  tetris_input_ctrl_if.slave   bus,
  output logic [1:0]           zone_dbg
);

  typedef enum logic [1:0] {
    ZONE_CENTER = 2'd0,
    ZONE_LEFT   = 2'd1,
    ZONE_RIGHT  = 2'd2
  } zone_t;

  localparam int TW = $clog2(ADC_TIMEOUT + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [ADC_W-1:0] L_ON  = ADC_W'(LEFT_ON);
  localparam logic [ADC_W-1:0] L_OFF = ADC_W'(LEFT_OFF);
  localparam logic [ADC_W-1:0] R_OFF = ADC_W'(RIGHT_OFF);
  localparam logic [ADC_W-1:0] R_ON  = ADC_W'(RIGHT_ON);
  localparam logic [TW-1:0]    TO_LAST = TW'(ADC_TIMEOUT - 1);
  localparam logic [DW-1:0]    DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  zone_t          zone;
  logic           move_left_q;
  logic           move_right_q;
  logic           stale_q;
  logic [TW-1:0]  idle_cnt;

  // Index 0 = rotate, index 1 = fast-drop.
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     db;
  logic [DW-1:0]  db_cnt [2];

  function automatic zone_t next_zone(input zone_t cur, input logic [ADC_W-1:0] v);
    zone_t nz;
    nz = cur;
    case (cur)
      ZONE_CENTER: begin
        if (v <= L_ON)      nz = ZONE_LEFT;
        else if (v >= R_ON) nz = ZONE_RIGHT;
      end
      ZONE_LEFT: begin
        if (v >= R_ON)       nz = ZONE_RIGHT;
        else if (v >= L_OFF) nz = ZONE_CENTER;
      end
      ZONE_RIGHT: begin
        if (v <= L_ON)       nz = ZONE_LEFT;
        else if (v <= R_OFF) nz = ZONE_CENTER;
      end
      default: nz = ZONE_CENTER;
    endcase
    return nz;
  endfunction

  // A valid sample always wins over the timeout reached on the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zone         <= ZONE_CENTER;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      stale_q      <= 1'b0;
      idle_cnt     <= '0;
    end else if (bus.adc_valid) begin
      zone         <= next_zone(zone, bus.adc_value);
      move_left_q  <= (next_zone(zone, bus.adc_value) == ZONE_LEFT);
      move_right_q <= (next_zone(zone, bus.adc_value) == ZONE_RIGHT);
      stale_q      <= 1'b0;
      idle_cnt     <= '0;
    end else if (idle_cnt != TW'(ADC_TIMEOUT)) begin
      idle_cnt <= idle_cnt + TW'(1);
      if (idle_cnt == TO_LAST) begin
        zone         <= ZONE_CENTER;
        move_left_q  <= 1'b0;
        move_right_q <= 1'b0;
        stale_q      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      db    <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {bus.btn_drop_n, bus.btn_rotate_n};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (~sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= ~sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign bus.move_left  = move_left_q;
  assign bus.move_right = move_right_q;
  assign bus.adc_stale  = stale_q;
  assign bus.rotate     = db[0];
  assign bus.move_down  = db[1];
  assign zone_dbg       = zone;

endmodule
